// File: rtl/four_two_encoder_seq_pkg.sv
// Shared definitions for the sequential request encoder: default sizing and FSM state encodings.
package four_two_encoder_seq_pkg;

    localparam int unsigned N_REQ_DEF  = 4;
    localparam int unsigned CODE_W_DEF = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

endpackage

// File: rtl/four_two_encoder_seq_prio_pick.sv
// Combinational priority picker: first set bit of cand, searching upward from base (mod N_REQ).
module four_two_encoder_seq_prio_pick
    import four_two_encoder_seq_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEF,
    parameter int unsigned CODE_W = CODE_W_DEF
) (
    input  logic [N_REQ-1:0]  cand,
    input  logic [CODE_W-1:0] base,
    output logic [CODE_W-1:0] idx,
    output logic              hit
);

    logic [CODE_W-1:0] pos_c;

    // Walk offsets from farthest to nearest so the offset closest to base wins.
    always_comb begin
        idx   = '0;
        hit   = 1'b0;
        pos_c = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            pos_c = base + CODE_W'(k);
            if (cand[pos_c]) begin
                idx = pos_c;
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/four_two_encoder_seq.sv
// Sequential request encoder: sticky pending mask, one binary code per valid/ready handshake.
// Define ENC_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module four_two_encoder_seq
    import four_two_encoder_seq_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEF,
    parameter int unsigned CODE_W = CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              drop
);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  pend_q, pend_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              drop_q, drop_d;

    logic [N_REQ-1:0]  new_req_c;
    logic [N_REQ-1:0]  cand_c;
    logic [N_REQ-1:0]  rest_c;
    logic [CODE_W-1:0] pick_idx_c;
    logic              pick_hit_c;
    logic [CODE_W-1:0] base_c;

    assign new_req_c = en ? req : '0;
    assign cand_c    = pend_q | new_req_c;
    assign rest_c    = cand_c & ~(N_REQ'(1) << pick_idx_c);

    four_two_encoder_seq_prio_pick #(
        .N_REQ  (N_REQ),
        .CODE_W (CODE_W)
    ) u_pick (
        .cand (cand_c),
        .base (base_c),
        .idx  (pick_idx_c),
        .hit  (pick_hit_c)
    );

`ifdef ENC_ROUND_ROBIN_EN
    logic [CODE_W-1:0] rr_base_q;
    logic              load_c;

    // A new code is loaded whenever the picker hits and the output slot is free.
    assign load_c = pick_hit_c & ((state_q == ST_IDLE) | ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_base_q <= '0;
        end else if (load_c) begin
            rr_base_q <= pick_idx_c + CODE_W'(1);
        end
    end

    assign base_c = rr_base_q;
`else
    assign base_c = '0;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        code_d  = code_q;
        valid_d = valid_q;
        drop_d  = |(new_req_c & pend_q);

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (pick_hit_c) begin
                    code_d  = pick_idx_c;
                    valid_d = 1'b1;
                    pend_d  = rest_c;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!ready) begin
                    pend_d = cand_c;
                end else if (pick_hit_c) begin
                    code_d  = pick_idx_c;
                    valid_d = 1'b1;
                    pend_d  = rest_c;
                end else begin
                    valid_d = 1'b0;
                    pend_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                pend_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign drop  = drop_q;
    assign busy  = (pend_q != '0) | valid_q;

endmodule

// File: tb/tb_four_two_encoder_seq.sv
// Directed self-checking bench for four_two_encoder_seq; expectations follow ENC_ROUND_ROBIN_EN.
module tb_four_two_encoder_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [1:0] code;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       drop;

    int total = 0;
    int bad   = 0;

    four_two_encoder_seq dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
        .code  (code),
        .valid (valid),
        .ready (ready),
        .busy  (busy),
        .drop  (drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [1:0] c,
                           input logic b, input logic d);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".code"},  32'(code),  32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".drop"},  32'(drop),  32'(d));
    endtask

    initial begin
        logic [1:0] exp_seq3 [3];
        logic [1:0] exp_seq6 [6];
`ifdef ENC_ROUND_ROBIN_EN
        exp_seq3 = '{2'd3, 2'd0, 2'd1};
        exp_seq6 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`else
        exp_seq3 = '{2'd0, 2'd1, 2'd3};
        exp_seq6 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

        // 1: reset held with all requests active
        rst = 1'b1; en = 1'b1; req = 4'b1111; ready = 1'b1;
        tick(); chk_all("rst0", 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); chk_all("rst1", 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; req = 4'b0000;
        tick(); chk_all("idle", 1'b0, 2'd0, 1'b0, 1'b0);

        // 2: single request, one-cycle latency
        req = 4'b0100;
        tick(); chk_all("single.grant", 1'b1, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        tick(); chk("single.done.valid", 32'(valid), 32'd0);
        chk("single.done.busy", 32'(busy), 32'd0);

        // 3: multi-hot, back-to-back grants
        req = 4'b1011;
        tick(); chk_all("multi.0", 1'b1, exp_seq3[0], 1'b1, 1'b0);
        req = 4'b0000;
        tick(); chk_all("multi.1", 1'b1, exp_seq3[1], 1'b1, 1'b0);
        tick(); chk_all("multi.2", 1'b1, exp_seq3[2], 1'b1, 1'b0);
        tick(); chk("multi.end.valid", 32'(valid), 32'd0);
        chk("multi.end.busy", 32'(busy), 32'd0);

        // 4: backpressure holds code stable
        ready = 1'b0; req = 4'b0010;
        tick(); chk_all("bp.grant", 1'b1, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick(); chk_all("bp.hold", 1'b1, 2'd1, 1'b1, 1'b0);
        end
        ready = 1'b1;
        tick(); chk_all("bp.accept", 1'b0, 2'd1, 1'b0, 1'b0);
        tick(); chk("bp.once.valid", 32'(valid), 32'd0);

        // 5: re-request of presented code pends; second repeat merges with drop pulse
        ready = 1'b0; req = 4'b1000;
        tick(); chk_all("merge.grant", 1'b1, 2'd3, 1'b1, 1'b0);
        tick(); chk_all("merge.pend", 1'b1, 2'd3, 1'b1, 1'b0);
        tick(); chk_all("merge.drop", 1'b1, 2'd3, 1'b1, 1'b1);
        req = 4'b0000;
        tick(); chk_all("merge.dropend", 1'b1, 2'd3, 1'b1, 1'b0);
        ready = 1'b1;
        tick(); chk_all("merge.regrant", 1'b1, 2'd3, 1'b1, 1'b0);
        tick(); chk_all("merge.end", 1'b0, 2'd3, 1'b0, 1'b0);
        en = 1'b0; req = 4'b1000;
        tick(); chk_all("en0.a", 1'b0, 2'd3, 1'b0, 1'b0);
        tick(); chk_all("en0.b", 1'b0, 2'd3, 1'b0, 1'b0);
        en = 1'b1; req = 4'b0000;

        // 6: all requests held, priority order per build
        req = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("all.valid", 32'(valid), 32'd1);
            chk($sformatf("all.code%0d", i), 32'(code), 32'(exp_seq6[i]));
        end

        // reset mid-SERVE discards pending and presented code
        ready = 1'b0;
        tick(); chk("midrst.pre.valid", 32'(valid), 32'd1);
        rst = 1'b1;
        tick(); chk_all("midrst", 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; req = 4'b0000; ready = 1'b1;
        tick(); chk_all("midrst.after", 1'b0, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
